// File: rtl/tach_pkg.sv
// Shared definitions for the encoder emulator and tachometer: timing defaults,
// window length derivation, quadrature state and the run-control FSM states.
package tach_pkg;

  localparam int unsigned DEFAULT_CLOCK_FREQ     = 100_000_000;
  localparam int unsigned DEFAULT_PERCENT_SECOND = 1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUN,
    ST_DRAIN
  } tach_state_t;

  // Encoded as {a, b}.
  typedef enum logic [1:0] {
    QUAD_00 = 2'b00,
    QUAD_10 = 2'b10,
    QUAD_11 = 2'b11,
    QUAD_01 = 2'b01
  } quad_t;

  function automatic int unsigned num_clocks(input int unsigned clock_freq,
                                             input int unsigned percent_second);
    return clock_freq / percent_second;
  endfunction

  // Forward: 00->10->11->01->00 (A leads B); reverse walks the cycle backwards.
  function automatic quad_t quad_step(input quad_t q, input logic fwd);
    case (q)
      QUAD_00: return fwd ? QUAD_10 : QUAD_01;
      QUAD_10: return fwd ? QUAD_11 : QUAD_00;
      QUAD_11: return fwd ? QUAD_01 : QUAD_10;
      QUAD_01: return fwd ? QUAD_00 : QUAD_11;
      default: return QUAD_00;
    endcase
  endfunction

endpackage

// File: rtl/window_timer.sv
// Free-running window counter 0..NUM_CLOCKS-1 with a tick on the last clock.
module window_timer #(
  parameter int unsigned NUM_CLOCKS = 100_000,
  parameter int          CNT_W      = 32
) (
  input  logic             clock,
  input  logic             system_reset,
  output logic [CNT_W-1:0] count,
  output logic             window_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CLOCKS - 1);

  always_ff @(posedge clock or negedge system_reset) begin
    if (!system_reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign window_tick = (count == LAST);

endmodule

// File: rtl/encoder_emulator.sv
// Quadrature encoder emulator: emits a requested number of A-channel pulses per
// window, spread evenly by a fractional accumulator, with a one-deep rate buffer.
module encoder_emulator
  import tach_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ     = DEFAULT_CLOCK_FREQ,
  parameter int unsigned PERCENT_SECOND = DEFAULT_PERCENT_SECOND
) (
  input  logic        clock,
  input  logic        system_reset,
  input  logic        enable,
  input  logic [31:0] rate_in,
  input  logic        direction_in,
  input  logic        rate_valid,
  output logic        rate_ready,
  output logic        enc_a,
  output logic        enc_b,
  output logic        window_tick,
  output logic [31:0] window_pulses,
  output logic        running,
  output logic        rate_clamped
);

  localparam int unsigned NUM_CLOCKS   = num_clocks(CLOCK_FREQ, PERCENT_SECOND);
  localparam int          CNT_W        = 32;
  localparam logic [31:0] MAX_RATE     = 32'(NUM_CLOCKS / 4);
  localparam logic [33:0] NUM_CLOCKS_W = 34'(NUM_CLOCKS);

  function automatic logic [31:0] clamp_rate(input logic [31:0] r);
    return (r > MAX_RATE) ? MAX_RATE : r;
  endfunction

  tach_state_t state_q, state_d;
  quad_t       quad_q, quad_d;
  logic [33:0] acc_q, acc_d, acc_sum, step_inc;
  logic [31:0] act_rate, pend_rate, pulse_cnt;
  logic        act_dir, pend_dir, pend_full;
  logic        step_now, a_rise;
  logic [1:0]  quad_bits_q, quad_bits_d;

  // The count is exported for the tachometer; the emulator only needs the tick.
  logic [CNT_W-1:0] win_count_unused;

  window_timer #(
    .NUM_CLOCKS(NUM_CLOCKS),
    .CNT_W     (CNT_W)
  ) u_window_timer (
    .clock       (clock),
    .system_reset(system_reset),
    .count       (win_count_unused),
    .window_tick (window_tick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_ARMED;
      ST_ARMED: if (!enable) state_d = ST_IDLE;
                else if (window_tick) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: if (enable) state_d = ST_RUN;
                else if (window_tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign running    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign rate_ready = ~pend_full;

  // Max rate is NUM_CLOCKS/4, so the increment never exceeds NUM_CLOCKS and at
  // most one step fires per clock; clearing at the tick makes each window exact.
  always_comb begin
    step_inc    = {act_rate, 2'b00};
    acc_sum     = acc_q + step_inc;
    step_now    = running && (acc_sum >= NUM_CLOCKS_W);
    quad_d      = step_now ? quad_step(quad_q, act_dir) : quad_q;
    quad_bits_q = quad_q;
    quad_bits_d = quad_d;
    a_rise      = step_now && !quad_bits_q[1] && quad_bits_d[1];
    if (!running || window_tick) begin
      acc_d = '0;
    end else if (step_now) begin
      acc_d = acc_sum - NUM_CLOCKS_W;
    end else begin
      acc_d = acc_sum;
    end
  end

  always_ff @(posedge clock or negedge system_reset) begin
    if (!system_reset) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      quad_q        <= QUAD_00;
      pulse_cnt     <= '0;
      window_pulses <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      quad_q  <= quad_d;
      if (window_tick) begin
        window_pulses <= pulse_cnt + {31'd0, a_rise};
        pulse_cnt     <= '0;
      end else begin
        pulse_cnt <= pulse_cnt + {31'd0, a_rise};
      end
    end
  end

  // Rate handoff: a pending value moves to active only at a window boundary.
  always_ff @(posedge clock or negedge system_reset) begin
    if (!system_reset) begin
      pend_full    <= 1'b0;
      pend_rate    <= '0;
      pend_dir     <= 1'b1;
      act_rate     <= '0;
      act_dir      <= 1'b1;
      rate_clamped <= 1'b0;
    end else if (rate_valid && !pend_full) begin
      pend_full    <= 1'b1;
      pend_rate    <= clamp_rate(rate_in);
      pend_dir     <= direction_in;
      rate_clamped <= (rate_in > MAX_RATE);
    end else if (window_tick && pend_full) begin
      pend_full <= 1'b0;
      act_rate  <= pend_rate;
      act_dir   <= pend_dir;
    end
  end

  assign enc_a = quad_bits_q[1];
  assign enc_b = quad_bits_q[0];

endmodule

// File: tb/tb_encoder_emulator.sv
// Directed bench for encoder_emulator with a 100-clock window.
module tb_encoder_emulator;

  localparam int N = 100;

  logic        clock = 1'b0;
  logic        system_reset;
  logic        enable;
  logic [31:0] rate_in;
  logic        direction_in;
  logic        rate_valid;
  logic        rate_ready;
  logic        enc_a, enc_b;
  logic        window_tick;
  logic [31:0] window_pulses;
  logic        running;
  logic        rate_clamped;

  int checks   = 0;
  int failures = 0;

  encoder_emulator #(
    .CLOCK_FREQ    (10000),
    .PERCENT_SECOND(100)
  ) dut (
    .clock        (clock),
    .system_reset (system_reset),
    .enable       (enable),
    .rate_in      (rate_in),
    .direction_in (direction_in),
    .rate_valid   (rate_valid),
    .rate_ready   (rate_ready),
    .enc_a        (enc_a),
    .enc_b        (enc_b),
    .window_tick  (window_tick),
    .window_pulses(window_pulses),
    .running      (running),
    .rate_clamped (rate_clamped)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rate;
    logic        dir;
    int          exp_pulses;
    logic        exp_clamped;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] model_next(input logic [1:0] q, input logic fwd);
    case (q)
      2'b00:   return fwd ? 2'b10 : 2'b01;
      2'b10:   return fwd ? 2'b11 : 2'b00;
      2'b11:   return fwd ? 2'b01 : 2'b10;
      default: return fwd ? 2'b00 : 2'b11;
    endcase
  endfunction

  task automatic wait_tick();
    bit seen = 0;
    for (int i = 0; i < 2 * N + 5 && !seen; i++) begin
      @(negedge clock);
      if (window_tick === 1'b1) seen = 1;
    end
    check("wait_tick_seen", seen, 1);
  endtask

  // Offer one rate at the start of a window so it is active from the next window.
  task automatic offer(input logic [31:0] r, input logic d, input logic exp_clamp);
    wait_tick();
    @(posedge clock); #1;
    check("ready_before_offer", rate_ready, 1);
    rate_in = r; direction_in = d; rate_valid = 1'b1;
    @(posedge clock); #1;
    rate_valid = 1'b0;
    check("ready_low_after_offer", rate_ready, 0);
    check("rate_clamped", rate_clamped, exp_clamp);
  endtask

  // Called right after a tick negedge; observes every step of the next window.
  task automatic monitor_window(input logic dir, input int exp_p);
    int         steps = 0, rises = 0;
    bit         illegal = 0, tick_bad = 0, run_bad = 0;
    logic [1:0] prev, cur, start;
    @(negedge clock);
    check("ready_after_tick", rate_ready, 1);
    prev  = {enc_a, enc_b};
    start = prev;
    for (int i = 0; i < N; i++) begin
      @(negedge clock);
      cur = {enc_a, enc_b};
      if (cur !== prev) begin
        steps++;
        if (cur !== model_next(prev, dir)) illegal = 1;
        if (!prev[1] && cur[1]) rises++;
      end
      if (window_tick !== (i == N - 2)) tick_bad = 1;
      if (running !== 1'b1) run_bad = 1;
      prev = cur;
    end
    check("steps_per_window", steps, 4 * exp_p);
    check("a_rises", rises, exp_p);
    check("illegal_step", illegal, 0);
    check("tick_period_err", tick_bad, 0);
    check("not_running", run_bad, 0);
    check("back_to_start", cur, start);
    check("window_pulses", window_pulses, exp_p);
  endtask

  initial begin
    bit moved;
    vecs[0] = '{32'd5,  1'b1, 5,  1'b0};
    vecs[1] = '{32'd30, 1'b1, 25, 1'b1};
    vecs[2] = '{32'd10, 1'b0, 10, 1'b0};
    vecs[3] = '{32'd0,  1'b1, 0,  1'b0};
    vecs[4] = '{32'd7,  1'b0, 7,  1'b0};
    vecs[5] = '{32'd25, 1'b0, 25, 1'b0};

    system_reset = 1'b0;
    enable = 1'b0; rate_in = '0; direction_in = 1'b1; rate_valid = 1'b0;
    #7;
    check("rst_enc", {enc_a, enc_b}, 0);
    check("rst_tick", window_tick, 0);
    check("rst_pulses", window_pulses, 0);
    check("rst_ready", rate_ready, 1);
    check("rst_running", running, 0);
    check("rst_clamped", rate_clamped, 0);
    repeat (3) @(posedge clock);
    #1 system_reset = 1'b1;
    enable = 1'b1;

    for (int v = 0; v < 6; v++) begin
      offer(vecs[v].rate, vecs[v].dir, vecs[v].exp_clamped);
      wait_tick();
      monitor_window(vecs[v].dir, vecs[v].exp_pulses);
    end

    // Drop enable mid-window: the window completes, then everything freezes at 00.
    offer(32'd7, 1'b1, 1'b0);
    wait_tick();
    repeat (40) @(posedge clock);
    #1 enable = 1'b0;
    @(negedge clock);
    check("drain_running", running, 1);
    wait_tick();
    @(negedge clock);
    check("drain_pulses", window_pulses, 7);
    check("drain_idle", running, 0);
    check("drain_enc", {enc_a, enc_b}, 0);
    moved = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      if ({enc_a, enc_b} !== 2'b00 || running !== 1'b0) moved = 1;
    end
    check("idle_frozen", moved, 0);
    check("idle_pulses", window_pulses, 0);

    // Asynchronous reset in the middle of a fast run with a rate still pending.
    enable = 1'b1;
    offer(32'd40, 1'b1, 1'b1);
    wait_tick();
    @(posedge clock);
    repeat (30) @(posedge clock);
    #1;
    check("pre_reset_enc", {enc_a, enc_b}, 2'b11);
    rate_in = 32'd9; rate_valid = 1'b1;
    @(posedge clock); #1;
    rate_valid = 1'b0;
    check("pre_reset_ready", rate_ready, 0);
    #2 system_reset = 1'b0;
    #1;
    check("arst_enc", {enc_a, enc_b}, 0);
    check("arst_running", running, 0);
    check("arst_ready", rate_ready, 1);
    check("arst_clamped", rate_clamped, 0);
    check("arst_pulses", window_pulses, 0);
    check("arst_tick", window_tick, 0);
    enable = 1'b0;
    repeat (2) @(posedge clock);
    #1 system_reset = 1'b1;
    moved = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clock);
      if ({enc_a, enc_b} !== 2'b00 || running !== 1'b0) moved = 1;
    end
    check("post_reset_quiet", moved, 0);
    enable = 1'b1;
    wait_tick();
    @(negedge clock);
    check("post_reset_run", running, 1);
    moved = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      if ({enc_a, enc_b} !== 2'b00) moved = 1;
    end
    check("rate_discarded", moved, 0);
    check("rate_discarded_pulses", window_pulses, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
